axi_slave_wr_arbiter: RTL and testbench

// Write-path controller in front of one slave port of the 4-master/7-slave AXI NoC.

---
 rtl/axi_slave_wr_arbiter.sv | 134 +++++++++++++
 tb/tb_axi_slave_wr_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_wr_arbiter.sv
// Write-path steering for one NoC slave port: round-robin AW arbitration, W lock until
// WLAST, and in-order B routing through a FIFO of issuing-master indices.
module axi_slave_wr_arbiter #(
  parameter  int NUM_M     = 4,
  parameter  int OUT_DEPTH = 4,
  localparam int SEL_W     = $clog2(NUM_M),
  localparam int CNT_W     = $clog2(OUT_DEPTH + 1),
  localparam int PTR_W     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [NUM_M-1:0] m_awvalid,
  output logic [NUM_M-1:0] m_awready,
  output logic             s_awvalid,
  input  logic             s_awready,
  output logic [SEL_W-1:0] aw_sel,
  input  logic [NUM_M-1:0] m_wvalid,
  input  logic [NUM_M-1:0] m_wlast,
  output logic [NUM_M-1:0] m_wready,
  output logic             s_wvalid,
  output logic             s_wlast,
  input  logic             s_wready,
  output logic [SEL_W-1:0] w_sel,
  input  logic             s_bvalid,
  output logic             s_bready,
  output logic [NUM_M-1:0] m_bvalid,
  input  logic [NUM_M-1:0] m_bready,
  output logic [SEL_W-1:0] b_sel,
  output logic [CNT_W-1:0] outstanding
);

  typedef enum logic [1:0] {IDLE, AW, W} state_t;

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             aw_hs, w_done, push, pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_empty = (outstanding == '0);
  assign fifo_full  = (outstanding == CNT_W'(OUT_DEPTH));
  assign aw_hs      = (state == AW) && s_awready;
  assign w_done     = (state == W) && s_wvalid && s_wready && s_wlast;
  assign push       = aw_hs && !fifo_full;
  assign b_sel      = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign pop        = !fifo_empty && s_bvalid && m_bready[b_sel];
  assign s_awvalid  = (state == AW);

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_M;
      if (!found && m_awvalid[idx]) begin
        grant = SEL_W'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state  <= IDLE;
      rr_ptr <= '0;
      aw_sel <= '0;
      w_sel  <= '0;
    end else begin
      case (state)
        IDLE: if ((|m_awvalid) && !fifo_full) begin
          aw_sel <= grant;
          state  <= AW;
        end
        AW: if (s_awready) begin
          w_sel  <= aw_sel;
          rr_ptr <= (aw_sel == SEL_W'(NUM_M - 1)) ? '0 : aw_sel + 1'b1;
          state  <= W;
        end
        W: if (w_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= aw_sel;
        wr_ptr           <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Ready/valid steering follows the registered selects only.
  always_comb begin
    m_awready = '0;
    m_wready  = '0;
    s_wvalid  = 1'b0;
    s_wlast   = 1'b0;
    m_bvalid  = '0;
    s_bready  = 1'b0;
    if (state == AW) m_awready[aw_sel] = s_awready;
    if (state == W) begin
      s_wvalid        = m_wvalid[w_sel];
      s_wlast         = m_wlast[w_sel];
      m_wready[w_sel] = s_wready;
    end
    if (!fifo_empty) begin
      m_bvalid[b_sel] = s_bvalid;
      s_bready        = m_bready[b_sel];
    end
  end

endmodule

// File: tb/tb_axi_slave_wr_arbiter.sv
// Bench for axi_slave_wr_arbiter: scenario tasks with a grant/B-routing scoreboard.
module tb_axi_slave_wr_arbiter;
  localparam int NUM_M = 4;
  localparam int OUT_DEPTH = 4;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic [3:0] m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
  logic       s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [1:0] aw_sel, w_sel, b_sel;
  logic [2:0] outstanding;

  int checks = 0;
  int failures = 0;
  int gnt_q[$];  // expected AW grant order
  int b_q[$];    // expected B routing order

  axi_slave_wr_arbiter #(.NUM_M(NUM_M), .OUT_DEPTH(OUT_DEPTH)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .s_awvalid(s_awvalid),
    .s_awready(s_awready), .aw_sel(aw_sel),
    .m_wvalid(m_wvalid), .m_wlast(m_wlast), .m_wready(m_wready),
    .s_wvalid(s_wvalid), .s_wlast(s_wlast), .s_wready(s_wready), .w_sel(w_sel),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .m_bvalid(m_bvalid),
    .m_bready(m_bready), .b_sel(b_sel), .outstanding(outstanding)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  // One write by master m, sole requester; checks grant and W steering.
  task automatic do_write(input int m, input int beats);
    int k = 0;
    m_awvalid[m] = 1'b1;
    #1;
    while (!s_awvalid && k < 20) begin tick(); k++; end
    checks++;
    if (s_awvalid !== 1'b1) begin
      failures++;
      $display("FAIL wr_aw_timeout got=%0b want=1", s_awvalid);
      m_awvalid[m] = 1'b0;
      return;
    end
    checks++;
    if (aw_sel !== 2'(m)) begin
      failures++; $display("FAIL wr_aw_sel got=%0d want=%0d", aw_sel, m);
    end
    tick();
    m_awvalid[m] = 1'b0;
    b_q.push_back(m);
    m_wvalid[m] = 1'b1;
    for (int b = 0; b < beats; b++) begin
      m_wlast[m] = (b == beats - 1);
      #1;
      checks++;
      if (w_sel !== 2'(m) || m_wready !== (4'b0001 << m) || s_wvalid !== 1'b1) begin
        failures++;
        $display("FAIL wr_w_steer got=sel%0d/rdy%b/v%b want=sel%0d/rdy%b/v1",
                 w_sel, m_wready, s_wvalid, m, 4'b0001 << m);
      end
      tick();
    end
    m_wvalid[m] = 1'b0;
    m_wlast[m]  = 1'b0;
  endtask

  task automatic test_reset;
    ARESETn = 1'b0;
    tick(); tick();
    ARESETn = 1'b1;
    #1;
    checks++;
    if ({s_awvalid, s_wvalid, s_wlast, s_bready, m_awready, m_wready, m_bvalid,
         aw_sel, w_sel, b_sel, outstanding} !== '0) begin
      failures++; $display("FAIL reset_outputs got=nonzero want=0 (out=%0d)", outstanding);
    end
    // Enter W for master 1, then reset mid-burst.
    m_awvalid[1] = 1'b1;
    tick(); tick();
    m_awvalid[1] = 1'b0;
    m_wvalid[1] = 1'b1;
    #1;
    checks++;
    if (s_wvalid !== 1'b1 || outstanding !== 3'd1) begin
      failures++; $display("FAIL reset_pre_w got=v%b/out%0d want=v1/out1", s_wvalid, outstanding);
    end
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    #1;
    checks++;
    if ({s_awvalid, s_wvalid, s_wlast, s_bready, m_awready, m_wready, m_bvalid,
         aw_sel, w_sel, b_sel, outstanding} !== '0) begin
      failures++;
      $display("FAIL reset_mid_burst got=wv%b/ws%0d/out%0d want=0", s_wvalid, w_sel, outstanding);
    end
    m_wvalid = '0;
  endtask

  task automatic test_single_write;
    m_awvalid = 4'b0100;
    #1;
    checks++;
    if (s_awvalid !== 1'b0) begin
      failures++; $display("FAIL single_aw_early got=%b want=0", s_awvalid);
    end
    tick();
    checks++;
    if (s_awvalid !== 1'b1 || aw_sel !== 2'd2 || m_awready !== 4'b0100) begin
      failures++;
      $display("FAIL single_aw got=v%b/sel%0d/rdy%b want=v1/sel2/rdy0100", s_awvalid, aw_sel, m_awready);
    end
    tick();
    m_awvalid = '0;
    m_wvalid  = 4'b0100;
    for (int b = 0; b < 4; b++) begin
      m_wlast = (b == 3) ? 4'b0100 : 4'b0000;
      #1;
      checks++;
      if (w_sel !== 2'd2 || m_wready !== 4'b0100 || s_wlast !== (b == 3)) begin
        failures++;
        $display("FAIL single_beat%0d got=sel%0d/rdy%b/last%b want=sel2/rdy0100", b, w_sel, m_wready, s_wlast);
      end
      tick();
    end
    m_wvalid = '0; m_wlast = '0;
    #1;
    checks++;
    if (s_wvalid !== 1'b0 || s_awvalid !== 1'b0 || outstanding !== 3'd1) begin
      failures++;
      $display("FAIL single_post_w got=wv%b/out%0d want=wv0/out1", s_wvalid, outstanding);
    end
    s_bvalid = 1'b1; m_bready = 4'b0100;
    #1;
    checks++;
    if (b_sel !== 2'd2 || m_bvalid !== 4'b0100 || s_bready !== 1'b1) begin
      failures++;
      $display("FAIL single_b got=sel%0d/bv%b/rdy%b want=sel2/bv0100/rdy1", b_sel, m_bvalid, s_bready);
    end
    tick();
    s_bvalid = 1'b0; m_bready = '0;
    checks++;
    if (outstanding !== 3'd0) begin
      failures++; $display("FAIL single_out_after_b got=%0d want=0", outstanding);
    end
  endtask

  task automatic test_round_robin;
    ARESETn = 1'b0; tick(); ARESETn = 1'b1;
    gnt_q = '{0, 1, 2, 3, 0};
    s_bvalid = 1'b1; m_bready = 4'b1111;
    m_wvalid = 4'b1111; m_wlast = 4'b1111; m_awvalid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      int k = 0;
      int e;
      #1;
      while (!s_awvalid && k < 20) begin tick(); k++; end
      e = gnt_q.pop_front();
      checks++;
      if (s_awvalid !== 1'b1 || aw_sel !== 2'(e)) begin
        failures++; $display("FAIL rr_grant%0d got=v%b/sel%0d want=v1/sel%0d", g, s_awvalid, aw_sel, e);
      end
      tick();
      checks++;
      if (w_sel !== 2'(e) || m_wready !== (4'b0001 << e)) begin
        failures++; $display("FAIL rr_w%0d got=sel%0d/rdy%b want=sel%0d", g, w_sel, m_wready, e);
      end
      tick();
    end
    m_awvalid = '0;
    tick();
    m_wvalid = '0; m_wlast = '0; s_bvalid = 1'b0; m_bready = '0;
    checks++;
    if (outstanding !== 3'd0) begin
      failures++; $display("FAIL rr_drain got=%0d want=0", outstanding);
    end
  endtask

  task automatic test_full;
    int e;
    int k = 0;
    s_bvalid = 1'b0;
    gnt_q = '{1, 2, 3, 0, 1};
    b_q.delete();
    m_wvalid = 4'b1111; m_wlast = 4'b1111; m_awvalid = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      k = 0;
      #1;
      while (!s_awvalid && k < 20) begin tick(); k++; end
      e = gnt_q.pop_front();
      checks++;
      if (s_awvalid !== 1'b1 || aw_sel !== 2'(e)) begin
        failures++; $display("FAIL full_grant%0d got=sel%0d want=sel%0d", g, aw_sel, e);
      end
      b_q.push_back(e);
      tick(); tick();
    end
    tick(); tick(); tick();
    checks++;
    if (s_awvalid !== 1'b0 || outstanding !== 3'd4) begin
      failures++; $display("FAIL full_hold got=v%b/out%0d want=v0/out4", s_awvalid, outstanding);
    end
    s_bvalid = 1'b1; m_bready = 4'b1111;
    #1;
    e = b_q.pop_front();
    checks++;
    if (b_sel !== 2'(e)) begin
      failures++; $display("FAIL full_b_head got=%0d want=%0d", b_sel, e);
    end
    tick();
    s_bvalid = 1'b0;
    checks++;
    if (outstanding !== 3'd3 || s_awvalid !== 1'b0) begin
      failures++; $display("FAIL full_after_pop got=out%0d/v%b want=out3/v0", outstanding, s_awvalid);
    end
    tick();
    e = gnt_q.pop_front();
    checks++;
    if (s_awvalid !== 1'b1 || aw_sel !== 2'(e)) begin
      failures++; $display("FAIL full_fifth_grant got=v%b/sel%0d want=v1/sel%0d", s_awvalid, aw_sel, e);
    end
    m_awvalid = '0;
    b_q.push_back(e);
    tick(); tick();
    m_wvalid = '0; m_wlast = '0;
    s_bvalid = 1'b1;
    k = 0;
    while (b_q.size() > 0 && k < 20) begin
      #1;
      e = b_q.pop_front();
      checks++;
      if (b_sel !== 2'(e) || m_bvalid !== (4'b0001 << e)) begin
        failures++; $display("FAIL full_drain got=sel%0d/bv%b want=sel%0d", b_sel, m_bvalid, e);
      end
      tick();
      k++;
    end
    s_bvalid = 1'b0; m_bready = '0;
    checks++;
    if (outstanding !== 3'd0) begin
      failures++; $display("FAIL full_empty got=%0d want=0", outstanding);
    end
  endtask

  task automatic test_b_order;
    int e;
    s_bvalid = 1'b0; m_bready = '0;
    b_q.delete();
    do_write(3, 1);
    do_write(1, 2);
    do_write(3, 1);
    s_bvalid = 1'b1; m_bready = 4'b0111;
    #1;
    checks++;
    if (b_sel !== 2'd3 || m_bvalid !== 4'b1000 || s_bready !== 1'b0) begin
      failures++;
      $display("FAIL border_stall got=sel%0d/bv%b/rdy%b want=sel3/bv1000/rdy0", b_sel, m_bvalid, s_bready);
    end
    tick();
    checks++;
    if (outstanding !== 3'd3) begin
      failures++; $display("FAIL border_stall_out got=%0d want=3", outstanding);
    end
    m_bready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      e = b_q.pop_front();
      checks++;
      if (b_sel !== 2'(e) || m_bvalid !== (4'b0001 << e) || s_bready !== 1'b1) begin
        failures++; $display("FAIL border_b%0d got=sel%0d/bv%b want=sel%0d", i, b_sel, m_bvalid, e);
      end
      tick();
    end
    s_bvalid = 1'b0; m_bready = '0;
    checks++;
    if (outstanding !== 3'd0) begin
      failures++; $display("FAIL border_out got=%0d want=0", outstanding);
    end
  endtask

  task automatic test_concurrent;
    int e;
    b_q.delete();
    do_write(0, 1);
    m_awvalid = 4'b0100;
    tick();
    s_bvalid = 1'b1; m_bready = 4'b1111;
    #1;
    e = b_q.pop_front();
    checks++;
    if (m_awready !== 4'b0100 || s_bready !== 1'b1 || b_sel !== 2'(e) || outstanding !== 3'd1) begin
      failures++;
      $display("FAIL conc_pre got=awr%b/brdy%b/sel%0d/out%0d want=0100/1/%0d/1",
               m_awready, s_bready, b_sel, outstanding, e);
    end
    tick();
    s_bvalid = 1'b0; m_awvalid = '0;
    b_q.push_back(2);
    checks++;
    if (outstanding !== 3'd1) begin
      failures++; $display("FAIL conc_push_pop got=%0d want=1", outstanding);
    end
    m_wvalid = 4'b0100; m_wlast = 4'b0100;
    tick();
    m_wvalid = '0; m_wlast = '0;
    s_bvalid = 1'b1;
    #1;
    e = b_q.pop_front();
    checks++;
    if (b_sel !== 2'(e) || m_bvalid !== 4'b0100) begin
      failures++; $display("FAIL conc_b got=sel%0d/bv%b want=sel%0d/bv0100", b_sel, m_bvalid, e);
    end
    tick();
    checks++;
    if (s_bready !== 1'b0 || m_bvalid !== 4'b0000 || outstanding !== 3'd0) begin
      failures++;
      $display("FAIL conc_stray_b got=rdy%b/bv%b/out%0d want=0/0000/0", s_bready, m_bvalid, outstanding);
    end
    tick();
    checks++;
    if (outstanding !== 3'd0) begin
      failures++; $display("FAIL conc_no_underflow got=%0d want=0", outstanding);
    end
    s_bvalid = 1'b0; m_bready = '0;
  endtask

  initial begin
    ARESETn = 1'b0;
    m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_bready = '0;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_full();
    test_b_order();
    test_concurrent();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
